// File: rtl/fma_pkg.sv
// Shared definitions for the FMA request front end: command encoding and the
// command word presented to the fused multiply-add unit.
package fma_pkg;

    localparam logic CMD_S = 1'b0;
    localparam logic CMD_D = 1'b1;

    function automatic logic [31:0] cmd_word(input logic cmd);
        return {31'b0, cmd};
    endfunction

endpackage

// File: rtl/fma_req_fifo.sv
// Request buffer: DEPTH-entry synchronous FIFO with wrap-around pointers and an
// occupancy count; storage is not reset, only the pointers and count are.
module fma_req_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 197
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push) begin
            mem_d[wr_q] = wdata;
            wr_d        = wr_q + AW'(1);
        end
        if (pop) begin
            rd_d = rd_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[rd_q];
    assign count = cnt_q;

endmodule

// File: rtl/fma_issue.sv
// Front end of the shared FMA: buffers requests, issues them at the per-command
// initiation interval, and returns each result with its tag at the fixed latency.
module fma_issue
    import fma_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4,
    parameter int LAT_S = 4,
    parameter int LAT_D = 6,
    parameter int II_S  = 1,
    parameter int II_D  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_cmd,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic [63:0]       in_x,
    input  logic [63:0]       in_y,
    input  logic [63:0]       in_z,
    output logic              req,
    output logic [31:0]       req_command,
    output logic [63:0]       x,
    output logic [63:0]       y,
    output logic [63:0]       z,
    input  logic [63:0]       rslt,
    input  logic [4:0]        flag,
    output logic              out_valid,
    output logic [TAG_W-1:0]  out_tag,
    output logic [63:0]       out_rslt,
    output logic [4:0]        out_flag
);

    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int EW    = 1 + TAG_W + 192;
    localparam int IIW   = $clog2(((II_S > II_D) ? II_S : II_D) + 1);
    localparam int FW    = $clog2(LAT_D + 2) + 1;
    localparam int S_OFF = LAT_D - LAT_S;
    localparam logic [IIW-1:0] II_S_M1 = IIW'(II_S - 1);
    localparam logic [IIW-1:0] II_D_M1 = IIW'(II_D - 1);

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic             cmd;
    } trk_t;

    logic [CW-1:0]    fifo_count;
    logic [EW-1:0]    fifo_rdata;
    logic             push, issue, capture;
    logic             head_cmd;
    logic [TAG_W-1:0] head_tag;
    logic [63:0]      head_x, head_y, head_z;

    logic             req_q, req_d;
    logic             cmd_q, cmd_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [63:0]      x_q, x_d, y_q, y_d, z_q, z_d;
    logic [IIW-1:0]   ii_q, ii_d;
    logic [FW-1:0]    inflight_q, inflight_d;
    trk_t [LAT_D-1:0] trk_q, trk_d;
    logic             out_valid_q, out_valid_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic [63:0]      out_rslt_q, out_rslt_d;
    logic [4:0]       out_flag_q, out_flag_d;

    assign in_ready = (fifo_count < CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign {head_cmd, head_tag, head_x, head_y, head_z} = fifo_rdata;

    fma_req_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (issue),
        .wdata ({in_cmd, in_tag, in_x, in_y, in_z}),
        .rdata (fifo_rdata),
        .count (fifo_count)
    );

    // A different command may only issue once the pipe is empty, since fma muxes
    // its result by the current command.
    always_comb begin
        issue = (fifo_count != '0) && (ii_q == '0) &&
                ((inflight_q == '0) || (head_cmd == cmd_q));
    end

    // Issue stage: register the request toward fma and reload the interval counter.
    always_comb begin
        req_d = issue;
        cmd_d = cmd_q;
        tag_d = tag_q;
        x_d   = x_q;
        y_d   = y_q;
        z_d   = z_q;
        ii_d  = (ii_q != '0) ? (ii_q - IIW'(1)) : ii_q;
        if (issue) begin
            cmd_d = head_cmd;
            tag_d = head_tag;
            x_d   = head_x;
            y_d   = head_y;
            z_d   = head_z;
            ii_d  = (head_cmd == CMD_D) ? II_D_M1 : II_S_M1;
        end
    end

    // Tracking stage: entries enter while req is on the bus, positioned so that
    // both commands reach the last stage in the cycle their result is valid.
    always_comb begin
        trk_d[0] = '0;
        for (int i = 1; i < LAT_D; i++) begin
            trk_d[i] = trk_q[i-1];
        end
        if (req_q) begin
            if (cmd_q == CMD_D) begin
                trk_d[0].valid = 1'b1;
                trk_d[0].tag   = tag_q;
                trk_d[0].cmd   = cmd_q;
            end else begin
                trk_d[S_OFF].valid = 1'b1;
                trk_d[S_OFF].tag   = tag_q;
                trk_d[S_OFF].cmd   = cmd_q;
            end
        end
    end

    // Result stage: capture rslt/flag as the tracked op leaves the last stage.
    always_comb begin
        capture     = trk_q[LAT_D-1].valid;
        inflight_d  = inflight_q + FW'(issue) - FW'(capture);
        out_valid_d = capture;
        out_tag_d   = out_tag_q;
        out_rslt_d  = out_rslt_q;
        out_flag_d  = out_flag_q;
        if (capture) begin
            out_tag_d  = trk_q[LAT_D-1].tag;
            out_rslt_d = (trk_q[LAT_D-1].cmd == CMD_S) ? {32'b0, rslt[31:0]} : rslt;
            out_flag_d = flag;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_q       <= 1'b0;
            cmd_q       <= CMD_S;
            tag_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            ii_q        <= '0;
            inflight_q  <= '0;
            trk_q       <= '0;
            out_valid_q <= 1'b0;
            out_tag_q   <= '0;
            out_rslt_q  <= '0;
            out_flag_q  <= '0;
        end else begin
            req_q       <= req_d;
            cmd_q       <= cmd_d;
            tag_q       <= tag_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            ii_q        <= ii_d;
            inflight_q  <= inflight_d;
            trk_q       <= trk_d;
            out_valid_q <= out_valid_d;
            out_tag_q   <= out_tag_d;
            out_rslt_q  <= out_rslt_d;
            out_flag_q  <= out_flag_d;
        end
    end

    assign req         = req_q;
    assign req_command = cmd_word(cmd_q);
    assign x           = x_q;
    assign y           = y_q;
    assign z           = z_q;
    assign out_valid   = out_valid_q;
    assign out_tag     = out_tag_q;
    assign out_rslt    = out_rslt_q;
    assign out_flag    = out_flag_q;

endmodule
